afifo_pop_reader: RTL and testbench



---
 rtl/afifo_pop_reader.sv | 77 +++++++
 tb/tb_afifo_pop_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_pop_reader.sv
// Pop-side reader for the 36K async FIFO wrappers: issues POP, captures DOUT a
// cycle later into a 2-entry skid buffer, and presents words on a valid/ready stream.
module afifo_pop_reader #(
   parameter int DATA_WIDTH = 36,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock1,
   input  logic                  Async_Flush,
   input  logic                  Enable,
   input  logic                  Empty,
   input  logic                  Underrun_Error,
   input  logic [DATA_WIDTH-1:0] DOUT,
   output logic                  POP,
   output logic                  M_VALID,
   input  logic                  M_READY,
   output logic [DATA_WIDTH-1:0] M_DATA,
   output logic [CNT_WIDTH-1:0]  Pop_Count,
   output logic                  Underrun_Sticky
);

   logic [1:0]            r_cnt;
   logic                  r_inf;
   logic [DATA_WIDTH-1:0] r_buf [2];
   logic                  r_head;
   logic                  r_tail;
   logic [CNT_WIDTH-1:0]  r_pop_cnt;
   logic                  r_sticky;

   logic                  w_valid;
   logic                  w_take;
   logic [2:0]            w_level;
   logic                  w_pop;

   assign w_valid = (r_cnt != 2'd0);
   assign w_take  = w_valid & M_READY;

   // Occupancy after this edge; a new POP is only safe if its word will fit
   // once it lands one cycle from now, so cnt + inf must stay within 2.
   assign w_level = {1'b0, r_cnt} + {2'b00, r_inf} - {2'b00, w_take};
   assign w_pop   = Enable & ~Empty & ~Async_Flush & (w_level < 3'd2);

   always_ff @(posedge clock1 or posedge Async_Flush) begin
      if (Async_Flush) begin
         r_cnt     <= 2'd0;
         r_inf     <= 1'b0;
         r_buf[0]  <= '0;
         r_buf[1]  <= '0;
         r_head    <= 1'b0;
         r_tail    <= 1'b0;
         r_pop_cnt <= '0;
         r_sticky  <= 1'b0;
      end else begin
         if (r_inf) begin
            r_buf[r_tail] <= DOUT;
            r_tail        <= ~r_tail;
         end
         if (w_take) begin
            r_head <= ~r_head;
         end
         r_cnt <= w_level[1:0];
         r_inf <= w_pop;
         if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + 1'b1;
         end
         if (Underrun_Error) begin
            r_sticky <= 1'b1;
         end
      end
   end

   assign POP             = w_pop;
   assign M_VALID         = w_valid;
   assign M_DATA          = w_valid ? r_buf[r_head] : '0;
   assign Pop_Count       = r_pop_cnt;
   assign Underrun_Sticky = r_sticky;

endmodule

// File: tb/tb_afifo_pop_reader.sv
// Self-checking bench for afifo_pop_reader: behavioural FIFO model feeding the
// reader, scoreboard of loaded words compared against the output stream.
module tb_afifo_pop_reader;

   localparam int DW = 36;
   localparam int CW = 4;

   logic          clk;
   logic          Async_Flush;
   logic          Enable;
   logic          fifo_empty;
   logic          Underrun_Error;
   logic [DW-1:0] DOUT;
   logic          POP;
   logic          M_VALID;
   logic          M_READY;
   logic [DW-1:0] M_DATA;
   logic [CW-1:0] Pop_Count;
   logic          Underrun_Sticky;

   afifo_pop_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clock1         (clk),
      .Async_Flush    (Async_Flush),
      .Enable         (Enable),
      .Empty          (fifo_empty),
      .Underrun_Error (Underrun_Error),
      .DOUT           (DOUT),
      .POP            (POP),
      .M_VALID        (M_VALID),
      .M_READY        (M_READY),
      .M_DATA         (M_DATA),
      .Pop_Count      (Pop_Count),
      .Underrun_Sticky(Underrun_Sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: DOUT carries the popped word during the cycle after POP.
   logic [DW-1:0] mem [0:255];
   int unsigned   wr_ptr = 0;
   int unsigned   rd_ptr = 0;
   initial DOUT = '0;
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (POP) begin
         DOUT   <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
   end

   int unsigned   vectors    = 0;
   int unsigned   miscompares = 0;
   logic [DW-1:0] exp_q [$];
   int unsigned   pops       = 0;
   int unsigned   takes      = 0;
   int unsigned   vld_cycles = 0;
   logic [7:0]    hist_pop   = '0;
   logic [7:0]    hist_vld   = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic monitor();
      if (Async_Flush) return;
      hist_pop = {hist_pop[6:0], POP};
      hist_vld = {hist_vld[6:0], M_VALID};
      if (POP) pops++;
      if (M_VALID) vld_cycles++;
      else chk("idle_data", M_DATA, 0);
      if (M_VALID && M_READY) begin
         if (exp_q.size() == 0) chk("extra_word", M_VALID, 0);
         else chk("data", M_DATA, exp_q.pop_front());
         takes++;
      end
      chk("occ_le2", ({1'b0, dut.r_cnt} + {2'b00, dut.r_inf}) <= 3'd2, 1);
   endtask

   // Sample at the falling edge, then return just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = base + DW'(i);
         exp_q.push_back(base + DW'(i));
         wr_ptr++;
      end
   endtask

   task automatic wait_takes(input int unsigned start, input int unsigned n, input int limit);
      int g = 0;
      while ((takes - start) < n && g < limit) begin
         tick();
         g++;
      end
   endtask

   task automatic do_reset();
      Async_Flush = 1'b1;
      tick();
      Async_Flush = 1'b0;
   endtask

   int unsigned b_pop, b_take, b_vld;
   int          n;

   initial begin
      Async_Flush    = 1'b1;
      Enable         = 1'b1;
      M_READY        = 1'b0;
      Underrun_Error = 1'b0;

      // Reset held with a non-empty FIFO and Enable high
      load(3, 36'h0_0000_0010);
      tick();
      tick();
      chk("rst_pop", POP, 0);
      chk("rst_valid", M_VALID, 0);
      chk("rst_count", Pop_Count, 0);
      chk("rst_sticky", Underrun_Sticky, 0);
      chk("rst_data", M_DATA, 0);
      Async_Flush = 1'b0;
      M_READY = 1'b1;
      b_take = takes;
      wait_takes(b_take, 3, 20);
      chk("rst_drain", takes - b_take, 3);
      chk("rst_drain_cnt", Pop_Count, 3);
      do_reset();

      // Streaming: four words, POP in cycles 0-3, M_VALID in cycles 2-5
      load(4, 36'h0_0000_0001);
      repeat (8) tick();
      chk("stream_pop_hist", hist_pop, 8'b1111_0000);
      chk("stream_vld_hist", hist_vld, 8'b0011_1100);
      chk("stream_pop_idle", POP, 0);
      chk("stream_count", Pop_Count, 4);
      do_reset();

      // Backpressure: only two words may be popped while M_READY is low
      M_READY = 1'b0;
      b_pop = pops;
      load(8, 36'h9_0000_0100);
      repeat (6) tick();
      chk("bp_pops", pops - b_pop, 2);
      chk("bp_pop_low", POP, 0);
      chk("bp_valid", M_VALID, 1);
      chk("bp_hold_data", M_DATA, 36'h9_0000_0100);
      M_READY = 1'b1;
      b_take = takes;
      n = 0;
      while ((takes - b_take) < 8 && n < 40) begin
         tick();
         n++;
      end
      chk("bp_no_gap_cycles", n, 8);
      chk("bp_count", Pop_Count, 8);
      do_reset();

      // Enable gating: stop after the third POP, then resume
      Enable = 1'b0;
      load(10, 36'h0_0000_0200);
      Enable = 1'b1;
      b_pop = pops;
      b_take = takes;
      n = 0;
      while ((pops - b_pop) < 3 && n < 20) begin
         tick();
         n++;
      end
      Enable = 1'b0;
      repeat (10) tick();
      chk("en_pops", pops - b_pop, 3);
      chk("en_takes", takes - b_take, 3);
      chk("en_pop_low", POP, 0);
      Enable = 1'b1;
      wait_takes(b_take, 10, 40);
      chk("en_total", takes - b_take, 10);
      chk("en_count", Pop_Count, 10);
      do_reset();

      // Counter wrap: 17 POPs on a 4-bit counter
      b_pop = pops;
      b_take = takes;
      load(17, 36'hA_0000_0300);
      wait_takes(b_take, 17, 60);
      chk("wrap_takes", takes - b_take, 17);
      chk("wrap_pops", pops - b_pop, 17);
      chk("wrap_count", Pop_Count, 1);

      // Underrun: single-cycle pulse latches until flush
      Underrun_Error = 1'b1;
      chk("udr_before_edge", Underrun_Sticky, 0);
      tick();
      Underrun_Error = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (Underrun_Sticky) n++;
         tick();
      end
      chk("udr_held", n, 100);
      Async_Flush = 1'b1;
      #1;
      chk("udr_flush_async", Underrun_Sticky, 0);
      tick();
      Async_Flush = 1'b0;
      chk("udr_after_flush", Underrun_Sticky, 0);

      // Flush one cycle after a POP: the in-flight word must vanish
      load(1, 36'h5_0000_0ABC);
      tick();
      Async_Flush = 1'b1;
      #1;
      chk("fl_pop", POP, 0);
      chk("fl_valid", M_VALID, 0);
      chk("fl_inflight_clear", dut.r_inf, 0);
      tick();
      Async_Flush = 1'b0;
      exp_q.delete();
      b_vld = vld_cycles;
      b_pop = pops;
      repeat (6) tick();
      chk("fl_no_output", vld_cycles - b_vld, 0);
      chk("fl_no_pop", pops - b_pop, 0);
      chk("fl_count", Pop_Count, 0);
      chk("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
